// File: rtl/param_store_queue.sv
// rtl/param_store_queue.sv - store queue with in-order commit, load priority and store-to-load forwarding
// Optional feature macro: SQ_FWD_EN (forwarding); without it, matching loads are held off via ld_conflict.

module param_store_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int ROB_W  = 4,
    parameter int PRD_W  = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   issue,
    input  logic                   mem_wen,
    input  logic                   mem_ren,
    input  logic [15:0]            immed,
    input  logic [ROB_W-1:0]       rob_in,
    input  logic [PRD_W-1:0]       p_rd_in,
    input  logic [DATA_W-1:0]      rs_data,
    input  logic [DATA_W-1:0]      rt_data,
    input  logic                   stall_hazard,
    input  logic                   retire_ST,
    input  logic [ROB_W-1:0]       retire_rob,
    input  logic                   recover,
    input  logic [ROB_W-1:0]       rec_rob,
    input  logic [DATA_W-1:0]      mem_rdata,
    output logic                   sq_full,
    output logic                   sq_empty,
    output logic [$clog2(DEPTH):0] sq_count,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    output logic                   mem_wen_out,
    output logic                   mem_ren_out,
    output logic                   isLS,
    output logic [DATA_W-1:0]      load_result,
    output logic [PRD_W-1:0]       ls_p_rd,
    output logic [ROB_W-1:0]       ls_rob,
    output logic                   ls_RegDest
`ifndef SQ_FWD_EN
    ,
    output logic                   ld_conflict
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] e_addr [DEPTH];
    logic [DATA_W-1:0] e_data [DEPTH];
    logic [ROB_W-1:0]  e_rob  [DEPTH];
    logic [DEPTH-1:0]  e_valid;
    logic [DEPTH-1:0]  e_ready;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;

    logic [DATA_W-1:0] ea_full;
    logic [ADDR_W-1:0] ld_addr;
    logic              raw_load;
    logic              load_go;
    logic              commit;
    logic              enq;
    logic              fwd_hit;
    logic [PTR_W-1:0]  scan_idx;
    logic [CNT_W-1:0]  nready;

    logic              cmp_valid;
    logic              cmp_regdest;
    logic [PRD_W-1:0]  cmp_prd;
    logic [ROB_W-1:0]  cmp_rob;
`ifdef SQ_FWD_EN
    logic [DATA_W-1:0] fwd_data;
    logic              cmp_hit;
    logic [DATA_W-1:0] cmp_data;
`endif

    logic unused_ok;
    assign unused_ok = ^{rec_rob, ea_full};

    assign ea_full  = rs_data + DATA_W'(signed'(immed));
    assign ld_addr  = ea_full[ADDR_W-1:0];

    assign sq_count = count;
    assign sq_full  = (count == CNT_W'(DEPTH));
    assign sq_empty = (count == '0);

    assign raw_load = issue & mem_ren & ~stall_hazard & ~recover & ~rst;
    assign enq      = issue & mem_wen & ~stall_hazard & ~recover & ~sq_full;

    // Valid entries are contiguous from head, so scanning outward from head
    // and letting later hits override earlier ones selects the youngest match.
    always_comb begin
        fwd_hit  = 1'b0;
        scan_idx = head;
`ifdef SQ_FWD_EN
        fwd_data = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head + PTR_W'(i);
            if (e_valid[scan_idx] && (e_addr[scan_idx] == ld_addr)) begin
                fwd_hit  = 1'b1;
`ifdef SQ_FWD_EN
                fwd_data = e_data[scan_idx];
`endif
            end
        end
    end

    always_comb begin
        nready = '0;
        for (int i = 0; i < DEPTH; i++) begin
            nready = nready + CNT_W'(e_valid[PTR_W'(i)] & e_ready[PTR_W'(i)]);
        end
    end

`ifdef SQ_FWD_EN
    assign load_go = raw_load;
`else
    assign load_go     = raw_load & ~fwd_hit;
    assign ld_conflict = raw_load & fwd_hit;
`endif

    // Recovery cycles are flush-only: nothing commits while ready entries are being re-counted.
    assign commit = e_valid[head] & e_ready[head] & ~load_go & ~recover & ~rst;

    assign mem_ren_out = load_go;
    assign mem_wen_out = commit;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        if (load_go) begin
            mem_addr = ld_addr;
        end else if (commit) begin
            mem_addr  = e_addr[head];
            mem_wdata = e_data[head];
        end
    end

    assign isLS       = cmp_valid;
    assign ls_RegDest = cmp_regdest;
    assign ls_p_rd    = cmp_prd;
    assign ls_rob     = cmp_rob;

    // Memory returns read data in the completion cycle, so the result mux sits after the register.
`ifdef SQ_FWD_EN
    assign load_result = (cmp_valid & cmp_regdest) ? (cmp_hit ? cmp_data : mem_rdata) : '0;
`else
    assign load_result = (cmp_valid & cmp_regdest) ? mem_rdata : '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            e_valid     <= '0;
            e_ready     <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            cmp_valid   <= 1'b0;
            cmp_regdest <= 1'b0;
            cmp_prd     <= '0;
            cmp_rob     <= '0;
`ifdef SQ_FWD_EN
            cmp_hit     <= 1'b0;
            cmp_data    <= '0;
`endif
        end else begin
            cmp_valid   <= enq | load_go;
            cmp_regdest <= load_go;
            cmp_prd     <= load_go ? p_rd_in : '0;
            cmp_rob     <= (enq | load_go) ? rob_in : '0;
`ifdef SQ_FWD_EN
            cmp_hit     <= load_go & fwd_hit;
            cmp_data    <= (load_go & fwd_hit) ? fwd_data : '0;
`endif
            if (recover) begin
                e_valid <= e_valid & e_ready;
                tail    <= head + nready[PTR_W-1:0];
                count   <= nready;
            end else begin
                if (commit) begin
                    e_valid[head] <= 1'b0;
                    e_ready[head] <= 1'b0;
                    head          <= head + PTR_W'(1);
                end
                if (retire_ST) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (e_valid[PTR_W'(i)] && (e_rob[PTR_W'(i)] == retire_rob) &&
                            !(commit && (PTR_W'(i) == head))) begin
                            e_ready[PTR_W'(i)] <= 1'b1;
                        end
                    end
                end
                if (enq) begin
                    e_addr[tail]  <= ld_addr;
                    e_data[tail]  <= rt_data;
                    e_rob[tail]   <= rob_in;
                    e_valid[tail] <= 1'b1;
                    e_ready[tail] <= 1'b0;
                    tail          <= tail + PTR_W'(1);
                end
                count <= count + CNT_W'(enq) - CNT_W'(commit);
            end
        end
    end

endmodule

// File: doc/param_store_queue.md
PARAM_STORE_QUEUE -- requirements
Module: param_store_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of store entries, power of two, at least 2.
REQ-002 SHALL have parameter DATA_W, default 32, width of register and memory data.
REQ-003 SHALL have parameter ADDR_W, default 16, width of the memory address.
REQ-004 SHALL have parameter ROB_W, default 4, width of the ROB tag.
REQ-005 SHALL have parameter PRD_W, default 6, width of the physical destination register.
REQ-006 SHALL have the following ports:
  clk  in  1  single clock; all state updates on the rising edge
  rst  in  1  synchronous, active-high reset
  issue  in  1  load/store station issues one memory op
  mem_wen  in  1  issued op is a store
  mem_ren  in  1  issued op is a load
  immed  in  16  signed offset
  rob_in  in  ROB_W  ROB tag of issued op
  p_rd_in  in  PRD_W  load destination register
  rs_data  in  DATA_W  base register value
  rt_data  in  DATA_W  store data
  stall_hazard  in  1  suppresses issue this cycle
  retire_ST  in  1  ROB retires a store
  retire_rob  in  ROB_W  tag of retiring store
  recover  in  1  flush speculative state
  rec_rob  in  ROB_W  recovery tag, informational only
  mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_ren_out
  sq_full  out  1  count == DEPTH
  sq_empty  out  1  count == 0
  sq_count  out  log2(DEPTH)+1  valid entries
  mem_addr  out  ADDR_W  memory address
  mem_wdata  out  DATA_W  memory write data
  mem_wen_out  out  1  memory write strobe
  mem_ren_out  out  1  memory read strobe
  isLS  out  1  completion valid to the arbiter
  load_result  out  DATA_W  load data
  ls_p_rd  out  PRD_W  completing destination register
  ls_rob  out  ROB_W  completing ROB tag
  ls_RegDest  out  1  completion writes a register (loads only)

Function
REQ-007 SHALL compute the address as (rs_data + sign-extended immed), truncated to ADDR_W bits.
REQ-008 SHALL enqueue a store when issue & mem_wen & !stall_hazard & !recover & !sq_full: {addr, rt_data, rob_in, ready=0} goes to tail, and tail advances modulo DEPTH.
REQ-009 SHALL drop a store issued while sq_full is high, using the registered count; a same-cycle dequeue does not free the slot for that store.
REQ-010 SHALL set ready on the single valid entry whose rob matches retire_rob when retire_ST is high; a tag with no match is ignored.
REQ-011 SHALL treat a cycle as a load cycle when issue & mem_ren & !stall_hazard & !recover; in a load cycle it drives mem_ren_out=1 and mem_addr=load address combinationally.
REQ-012 SHALL commit the head entry when it is valid and ready and the cycle is not a load cycle: mem_wen_out=1, mem_addr and mem_wdata from head; head advances on that edge.
REQ-013 SHALL give loads priority over commits; the head entry holds until a non-load cycle.
REQ-014 SHALL forward, in a load cycle, data from the youngest valid entry whose address equals the load address; this includes an entry being committed that cycle.
REQ-015 SHALL register load completion one cycle after the load cycle: isLS=1, ls_RegDest=1, ls_p_rd, ls_rob, and load_result = forwarded data if matched, else mem_rdata.
REQ-016 SHALL register store completion one cycle after enqueue: isLS=1, ls_RegDest=0, ls_rob=rob_in, load_result=0.
REQ-017 SHALL keep mem_wen_out, mem_ren_out and isLS at 0 in idle cycles; mem_addr and mem_wdata are don't-care when both strobes are low.
REQ-018 SHALL, on recover, invalidate every entry with ready=0 and set tail to head plus the number of ready entries (ready entries are contiguous from head); it suppresses any completion registered that cycle.
REQ-019 SHALL wrap head and tail pointers modulo DEPTH, with full and empty derived from sq_count.

Reset
REQ-020 SHALL, while rst is high at a clock edge, clear all valid and ready bits, set head=tail=0 and sq_count=0, and drive sq_empty=1, sq_full=0, isLS=0, ls_RegDest=0, load_result=0, ls_p_rd=0, ls_rob=0, mem_wen_out=0, mem_ren_out=0.
REQ-021 SHALL take reset priority over every simultaneous event, including reset in the middle of a commit or load.

Configuration
REQ-022 SHALL compile store-to-load forwarding in when SQ_FWD_EN is defined (REQ-014 applies). Without it, a load matching any valid entry is not issued: mem_ren_out=0, no completion, and ld_conflict (out, 1) is driven high that cycle; the port exists only without the macro.

Verification
REQ-023 Four stores (addr 1..4, data 0x1234/0x2345/0x4567/0x5678, rob 2..5) -> sq_full=1, sq_count=4; a fifth store (rob 6) is dropped and gives no completion.
REQ-024 Retire rob 2, then rob 3, with no loads -> commits addr 1 data 0x1234, then addr 2 data 0x2345; head advances each cycle.
REQ-025 A load to addr 1 in the same cycle as a ready head -> mem_ren_out=1, mem_wen_out=0, head unchanged; commit happens in the next non-load cycle.
REQ-026 With SQ_FWD_EN, load addr 3 (entry data 0x4567, p_rd 2) -> next cycle isLS=1, ls_RegDest=1, ls_p_rd=2, load_result=0x4567, no memory data used.
REQ-027 Two ready entries plus two non-ready entries, then recover=1 -> sq_count=2, tail=head+2, the next store lands in the freed slot; wrap-around is checked with DEPTH=4.
REQ-028 Assert rst during a commit -> all outputs at reset values next cycle and the queue is empty.
